lut_wvf_sequencer: RTL and testbench

Segment scheduler for an externally-counted LUT waveform generator: it holds a small programmable table of segments (sample hold time, number of full periods, idle gap) and steps through them. For each segment it drives the generator's enable and wait-cycle input and counts completed periods from the generator's end-of-period flag. It sits between the register/config interface and one `LUT_WVF_GEN` instance built with external wait counting, and produces frequency-hopping bursts or repeated stimulus patterns without CPU involvement.

---
 rtl/lut_wvf_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_lut_wvf_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_wvf_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lut_wvf_sequencer
// Brief    : Segment-table scheduler for an externally counted LUT waveform
//            generator: drives enable / wait cycles and counts periods.
// Revision : 1.0 - initial release
// ============================================================================
module lut_wvf_sequencer #(
    parameter int NUM_SEG    = 4,
    parameter int WAIT_WIDTH = 10,
    parameter int PER_WIDTH  = 8,
    parameter int GAP_WIDTH  = 12
) (
    input  logic                       CLK_SYS,
    input  logic                       nRST,
    input  logic                       START,
    input  logic                       ABORT,
    input  logic                       LOOP,
    input  logic                       CFG_WE,
    input  logic [$clog2(NUM_SEG)-1:0] CFG_ADDR,
    input  logic [WAIT_WIDTH-1:0]      CFG_WAIT,
    input  logic [PER_WIDTH-1:0]       CFG_PERIODS,
    input  logic [GAP_WIDTH-1:0]       CFG_GAP,
    input  logic                       CFG_LAST,
    input  logic                       GEN_LUT_END,
    output logic                       GEN_EN,
    output logic [WAIT_WIDTH-1:0]      GEN_WAIT_CYC,
    output logic                       BUSY,
    output logic [$clog2(NUM_SEG)-1:0] SEG_IDX,
    output logic                       DONE,
    output logic                       CFG_ERR
);

    localparam int                    c_idx_w    = $clog2(NUM_SEG);
    localparam logic [c_idx_w-1:0]    c_last_idx = c_idx_w'(NUM_SEG - 1);
    localparam logic [WAIT_WIDTH-1:0] c_wait_one = WAIT_WIDTH'(1);
    localparam logic [PER_WIDTH-1:0]  c_per_one  = PER_WIDTH'(1);
    localparam logic [GAP_WIDTH-1:0]  c_gap_one  = GAP_WIDTH'(1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_load = 2'd1;
    localparam logic [1:0] c_st_run  = 2'd2;
    localparam logic [1:0] c_st_gap  = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [c_idx_w-1:0]    seg_idx_q, seg_idx_d;
    logic                  done_q, done_d;
    logic                  cfg_err_q;

    logic [WAIT_WIDTH-1:0] tbl_wait_q [NUM_SEG];
    logic [PER_WIDTH-1:0]  tbl_per_q  [NUM_SEG];
    logic [GAP_WIDTH-1:0]  tbl_gap_q  [NUM_SEG];
    logic                  tbl_last_q [NUM_SEG];

    logic [WAIT_WIDTH-1:0] act_wait_q, act_wait_d;
    logic [PER_WIDTH-1:0]  act_per_q, act_per_d;
    logic [GAP_WIDTH-1:0]  act_gap_q, act_gap_d;
    logic                  act_last_q, act_last_d;
    logic [PER_WIDTH-1:0]  per_cnt_q, per_cnt_d;
    logic [GAP_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
    logic                  lut_end_q, lut_end_d;

    logic                  w_addr_ok;
    logic                  w_cfg_ok;
    logic                  w_seg_end;
    logic [WAIT_WIDTH-1:0] w_sel_wait;
    logic [PER_WIDTH-1:0]  w_sel_per;
    logic [GAP_WIDTH-1:0]  w_sel_gap;
    logic                  w_sel_last;

    // Only non-power-of-two tables can be addressed past their end.
    generate
        if ((1 << c_idx_w) > NUM_SEG) begin : g_addr_chk
            assign w_addr_ok = ({{(32 - c_idx_w){1'b0}}, CFG_ADDR} < 32'(NUM_SEG));
        end else begin : g_addr_full
            assign w_addr_ok = 1'b1;
        end
    endgenerate

    assign w_cfg_ok = CFG_WE && w_addr_ok && (CFG_WAIT != '0) && (CFG_PERIODS != '0);

    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            cfg_err_q <= 1'b0;
            for (int i = 0; i < NUM_SEG; i++) begin
                tbl_wait_q[i] <= c_wait_one;
                tbl_per_q[i]  <= c_per_one;
                tbl_gap_q[i]  <= '0;
                tbl_last_q[i] <= 1'b0;
            end
        end else begin
            cfg_err_q <= CFG_WE && !w_cfg_ok;
            for (int i = 0; i < NUM_SEG; i++) begin
                if (w_cfg_ok && (CFG_ADDR == c_idx_w'(i))) begin
                    tbl_wait_q[i] <= CFG_WAIT;
                    tbl_per_q[i]  <= CFG_PERIODS;
                    tbl_gap_q[i]  <= CFG_GAP;
                    tbl_last_q[i] <= CFG_LAST;
                end
            end
        end
    end

    always_comb begin
        w_sel_wait = c_wait_one;
        w_sel_per  = c_per_one;
        w_sel_gap  = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < NUM_SEG; i++) begin
            if (seg_idx_q == c_idx_w'(i)) begin
                w_sel_wait = tbl_wait_q[i];
                w_sel_per  = tbl_per_q[i];
                w_sel_gap  = tbl_gap_q[i];
                w_sel_last = tbl_last_q[i];
            end
        end
    end

    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        seg_idx_d  = seg_idx_q;
        done_d     = 1'b0;
        act_wait_d = act_wait_q;
        act_per_d  = act_per_q;
        act_gap_d  = act_gap_q;
        act_last_d = act_last_q;
        per_cnt_d  = per_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        lut_end_d  = lut_end_q;
        w_seg_end  = 1'b0;

        if (ABORT) begin
            state_d   = c_st_idle;
            seg_idx_d = '0;
        end else begin
            case (state_q)
                c_st_idle: begin
                    if (START) begin
                        state_d   = c_st_load;
                        seg_idx_d = '0;
                    end
                end
                c_st_load: begin
                    act_wait_d = w_sel_wait;
                    act_per_d  = w_sel_per;
                    act_gap_d  = w_sel_gap;
                    act_last_d = w_sel_last;
                    per_cnt_d  = '0;
                    lut_end_d  = 1'b0;
                    state_d    = c_st_run;
                end
                c_st_run: begin
                    lut_end_d = GEN_LUT_END;
                    // Only the falling edge marks a completed period.
                    if (lut_end_q && !GEN_LUT_END) begin
                        per_cnt_d = per_cnt_q + c_per_one;
                        if (per_cnt_d == act_per_q) begin
                            if (act_gap_q != '0) begin
                                state_d   = c_st_gap;
                                gap_cnt_d = '0;
                            end else begin
                                w_seg_end = 1'b1;
                            end
                        end
                    end
                end
                c_st_gap: begin
                    if ((gap_cnt_q + c_gap_one) == act_gap_q) begin
                        w_seg_end = 1'b1;
                    end else begin
                        gap_cnt_d = gap_cnt_q + c_gap_one;
                    end
                end
                default: state_d = c_st_idle;
            endcase

            if (w_seg_end) begin
                if (act_last_q || (seg_idx_q == c_last_idx)) begin
                    seg_idx_d = '0;
                    if (LOOP) begin
                        state_d = c_st_load;
                    end else begin
                        state_d = c_st_idle;
                        done_d  = 1'b1;
                    end
                end else begin
                    seg_idx_d = seg_idx_q + 1'b1;
                    state_d   = c_st_load;
                end
            end
        end
    end

    always_ff @(posedge CLK_SYS or negedge nRST) begin
        if (!nRST) begin
            seg_idx_q  <= '0;
            done_q     <= 1'b0;
            act_wait_q <= c_wait_one;
            act_per_q  <= c_per_one;
            act_gap_q  <= '0;
            act_last_q <= 1'b0;
            per_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            lut_end_q  <= 1'b0;
        end else begin
            seg_idx_q  <= seg_idx_d;
            done_q     <= done_d;
            act_wait_q <= act_wait_d;
            act_per_q  <= act_per_d;
            act_gap_q  <= act_gap_d;
            act_last_q <= act_last_d;
            per_cnt_q  <= per_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            lut_end_q  <= lut_end_d;
        end
    end

    always_comb begin
        GEN_EN = (state_q == c_st_run);
        BUSY   = (state_q != c_st_idle);
    end

    assign GEN_WAIT_CYC = act_wait_q;
    assign SEG_IDX      = seg_idx_q;
    assign DONE         = done_q;
    assign CFG_ERR      = cfg_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lut_wvf_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lut_wvf_sequencer
// Brief    : Directed bench for lut_wvf_sequencer with an 8-bit LUT generator
//            model (256 samples per period).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lut_wvf_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, loop_en;
    logic        cfg_we, cfg_we5;
    logic [1:0]  cfg_addr;
    logic [2:0]  cfg_addr5;
    logic [9:0]  cfg_wait;
    logic [7:0]  cfg_per;
    logic [11:0] cfg_gap;
    logic        cfg_last;
    logic        lut_end;
    logic        gen_en, busy, done, cfg_err;
    logic [9:0]  gen_wait;
    logic [1:0]  seg_idx;
    logic        gen_en5, busy5, done5, cfg_err5;
    logic [9:0]  gen_wait5;
    logic [2:0]  seg_idx5;

    logic [7:0]  g_samp;
    logic [9:0]  g_hold;

    int n_assert = 0;
    int n_fail   = 0;
    int n;

    always #5 clk = ~clk;

    lut_wvf_sequencer u_dut (
        .CLK_SYS(clk), .nRST(rst_n), .START(start), .ABORT(abort), .LOOP(loop_en),
        .CFG_WE(cfg_we), .CFG_ADDR(cfg_addr), .CFG_WAIT(cfg_wait),
        .CFG_PERIODS(cfg_per), .CFG_GAP(cfg_gap), .CFG_LAST(cfg_last),
        .GEN_LUT_END(lut_end), .GEN_EN(gen_en), .GEN_WAIT_CYC(gen_wait),
        .BUSY(busy), .SEG_IDX(seg_idx), .DONE(done), .CFG_ERR(cfg_err)
    );

    // A 4-entry table has a 2-bit address, so address 5 is exercised on a 5-entry instance.
    lut_wvf_sequencer #(.NUM_SEG(5)) u_dut5 (
        .CLK_SYS(clk), .nRST(rst_n), .START(1'b0), .ABORT(1'b0), .LOOP(1'b0),
        .CFG_WE(cfg_we5), .CFG_ADDR(cfg_addr5), .CFG_WAIT(cfg_wait),
        .CFG_PERIODS(cfg_per), .CFG_GAP(cfg_gap), .CFG_LAST(cfg_last),
        .GEN_LUT_END(1'b0), .GEN_EN(gen_en5), .GEN_WAIT_CYC(gen_wait5),
        .BUSY(busy5), .SEG_IDX(seg_idx5), .DONE(done5), .CFG_ERR(cfg_err5)
    );

    // Generator model: each of 256 samples held GEN_WAIT_CYC cycles; flag on the last sample.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_samp <= '0;
            g_hold <= '0;
        end else if (!gen_en) begin
            g_samp <= '0;
            g_hold <= '0;
        end else if (g_hold >= gen_wait - 10'd1) begin
            g_hold <= '0;
            g_samp <= g_samp + 8'd1;
        end else begin
            g_hold <= g_hold + 10'd1;
        end
    end
    assign lut_end = (g_samp == 8'hFF);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cnt = 1);
        repeat (cnt) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [9:0] w, input logic [7:0] p,
                             input logic [11:0] g, input logic l);
        cfg_we = 1'b1; cfg_addr = a; cfg_wait = w; cfg_per = p; cfg_gap = g; cfg_last = l;
        tick();
        cfg_we = 1'b0;
    endtask

    // Returns in the LOAD cycle.
    task automatic start_seq;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Consecutive cycles with GEN_EN == lvl, from the current one; bounded.
    task automatic run_len(input logic lvl, output int cnt);
        cnt = 0;
        while (gen_en === lvl && cnt < 20000) begin
            cnt++;
            tick();
        end
    endtask

    // Called in the first RUN cycle of a segment; returns in the first cycle after it.
    task automatic seg(input string tag, input int idx, input int wt, input int hi);
        int len;
        check({tag, "_idx"}, 32'(seg_idx), 32'(idx));
        check({tag, "_wait"}, 32'(gen_wait), 32'(wt));
        check({tag, "_en"}, 32'(gen_en), 32'd1);
        run_len(1'b1, len);
        check({tag, "_hi"}, 32'(len), 32'(hi));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
        cfg_we = 1'b0; cfg_we5 = 1'b0; cfg_addr = '0; cfg_addr5 = '0;
        cfg_wait = 10'd1; cfg_per = 8'd1; cfg_gap = '0; cfg_last = 1'b0;
        tick(2);
        check("rst_en", 32'(gen_en), 0);
        check("rst_wait", 32'(gen_wait), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_idx", 32'(seg_idx), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(cfg_err), 0);
        rst_n = 1'b1;
        tick();

        // Single segment: 3*256*2 + 1 high cycles.
        cfg_write(2'd0, 10'd3, 8'd2, 12'd0, 1'b1);
        check("s_cfg_ok", 32'(cfg_err), 0);
        start_seq();
        check("s_load_en", 32'(gen_en), 0);
        check("s_load_busy", 32'(busy), 1);
        tick();
        seg("s0", 0, 3, 1537);
        check("s_done", 32'(done), 1);
        check("s_busy", 32'(busy), 0);
        tick();
        check("s_done_clr", 32'(done), 0);

        // Frequency hop: 513 high, 6 low, 7*256*3 + 1 high.
        cfg_write(2'd0, 10'd2, 8'd1, 12'd5, 1'b0);
        cfg_write(2'd1, 10'd7, 8'd3, 12'd0, 1'b1);
        start_seq();
        check("h_load_idx", 32'(seg_idx), 0);
        tick();
        seg("h0", 0, 2, 513);
        run_len(1'b0, n);
        check("h_gap_lo", 32'(n), 6);
        seg("h1", 1, 7, 5377);
        check("h_done", 32'(done), 1);
        tick();

        // Loop, with entry 0 rewritten while it runs.
        loop_en = 1'b1;
        start_seq();
        tick();
        check("l0_wait", 32'(gen_wait), 2);
        check("l0_idx", 32'(seg_idx), 0);
        cfg_write(2'd0, 10'd1, 8'd1, 12'd5, 1'b0);
        run_len(1'b1, n);
        check("l0_hi", 32'(n + 1), 513);
        run_len(1'b0, n);
        check("l0_lo", 32'(n), 6);
        seg("l1", 1, 7, 5377);
        check("l_wrap_done", 32'(done), 0);
        check("l_wrap_idx", 32'(seg_idx), 0);
        check("l_wrap_busy", 32'(busy), 1);
        tick();
        loop_en = 1'b0;
        seg("l2", 0, 1, 257);
        run_len(1'b0, n);
        check("l2_lo", 32'(n), 6);
        seg("l3", 1, 7, 5377);
        check("l_done", 32'(done), 1);
        tick();

        // Abort in the middle of segment 1.
        start_seq();
        tick();
        seg("a0", 0, 1, 257);
        run_len(1'b0, n);
        check("a_gap_lo", 32'(n), 6);
        check("a1_idx", 32'(seg_idx), 1);
        check("a1_en", 32'(gen_en), 1);
        tick(20);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("a_en", 32'(gen_en), 0);
        check("a_busy", 32'(busy), 0);
        check("a_idx", 32'(seg_idx), 0);
        check("a_done", 32'(done), 0);
        tick();
        check("a_done_late", 32'(done), 0);
        start = 1'b1; abort = 1'b1;
        tick();
        check("sa_busy", 32'(busy), 0);
        tick();
        check("sa_busy2", 32'(busy), 0);
        check("sa_en", 32'(gen_en), 0);
        start = 1'b0; abort = 1'b0;

        // Rejected writes.
        cfg_write(2'd2, 10'd0, 8'd1, 12'd0, 1'b0);
        check("e_wait0", 32'(cfg_err), 1);
        tick();
        check("e_wait0_clr", 32'(cfg_err), 0);
        cfg_write(2'd3, 10'd1, 8'd0, 12'd0, 1'b0);
        check("e_per0", 32'(cfg_err), 1);
        tick();
        check("e_per0_clr", 32'(cfg_err), 0);
        cfg_we5 = 1'b1; cfg_addr5 = 3'd5; cfg_wait = 10'd4; cfg_per = 8'd2;
        tick();
        cfg_we5 = 1'b0;
        check("e_addr5", 32'(cfg_err5), 1);
        tick();
        check("e_addr5_clr", 32'(cfg_err5), 0);
        cfg_we5 = 1'b1; cfg_addr5 = 3'd4;
        tick();
        cfg_we5 = 1'b0;
        check("e_addr4_ok", 32'(cfg_err5), 0);

        // Entries 2 and 3 must still be {1,1,0,0}.
        cfg_write(2'd0, 10'd1, 8'd1, 12'd0, 1'b0);
        cfg_write(2'd1, 10'd1, 8'd1, 12'd0, 1'b0);
        start_seq();
        tick();
        seg("c0", 0, 1, 257);
        tick();
        seg("c1", 1, 1, 257);
        tick();
        seg("c2", 2, 1, 257);
        run_len(1'b0, n);
        check("c2_lo", 32'(n), 1);
        seg("c3", 3, 1, 257);
        check("c_done", 32'(done), 1);
        tick();

        // Asynchronous reset in GAP.
        cfg_write(2'd0, 10'd2, 8'd1, 12'd5, 1'b0);
        start_seq();
        tick();
        seg("r0", 0, 2, 513);
        tick(2);
        check("r_gap_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("r_en", 32'(gen_en), 0);
        check("r_wait", 32'(gen_wait), 1);
        check("r_busy", 32'(busy), 0);
        check("r_idx", 32'(seg_idx), 0);
        check("r_done", 32'(done), 0);
        check("r_err", 32'(cfg_err), 0);
        tick();
        rst_n = 1'b1;
        tick();
        start_seq();
        tick();
        seg("d0", 0, 1, 257);
        run_len(1'b0, n);
        check("d0_lo", 32'(n), 1);
        seg("d1", 1, 1, 257);
        n = 0;
        while (!done && n < 2000) begin
            n++;
            tick();
        end
        check("d_done", 32'(done), 1);
        check("d_busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
